// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, state encoding and enable literals for the SRAM arbiter
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  localparam logic EN_ON  = 1'b1;
  localparam logic EN_OFF = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_MEM = 2'd1,
    ST_GRANT_IF  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - pipeline requester and SRAM pin bundle around the arbiter
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic              if_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              stall_req;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_data, if_ack, mem_rdata, mem_ack, stall_req,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_data, if_ack, mem_rdata, mem_ack, stall_req,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority (MEM over IF) sequencer for the single shared SRAM
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    bus
);

  localparam int               CNT_W    = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_if_ack;
  logic              r_mem_ack;
  logic [DATA_W-1:0] r_if_data;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              w_take_mem;
  logic              w_take_if;
  logic              w_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A requester whose ack is high this cycle is skipped so a held req is not served twice.
  always_comb begin
    w_next_state = r_state;
    w_take_mem   = 1'b0;
    w_take_if    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.mem_req && !r_mem_ack) begin
          w_take_mem   = 1'b1;
          w_next_state = ST_GRANT_MEM;
        end else if (bus.if_req && !r_if_ack) begin
          w_take_if    = 1'b1;
          w_next_state = ST_GRANT_IF;
        end
      end
      ST_GRANT_MEM, ST_GRANT_IF: begin
        if (r_cnt == CNT_LAST) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      if (w_take_mem) begin
        r_addr  <= bus.mem_addr;
        r_we    <= bus.mem_we;
        r_wdata <= bus.mem_wdata;
        r_cnt   <= '0;
      end else if (w_take_if) begin
        r_addr <= bus.if_addr;
        r_we   <= 1'b0;
        r_cnt  <= '0;
      end else if (w_done) begin
        r_cnt <= '0;
        if (r_state == ST_GRANT_IF) begin
          r_if_data <= bus.ram_rdata;
          r_if_ack  <= 1'b1;
        end else begin
          r_mem_ack <= 1'b1;
          if (!r_we) begin
            r_mem_rdata <= bus.ram_rdata;
          end
        end
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.ram_en    = (r_state != ST_IDLE) ? EN_ON : EN_OFF;
  assign bus.ram_we    = (r_state == ST_GRANT_MEM && r_we) ? EN_ON : EN_OFF;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.if_data   = r_if_data;
  assign bus.if_ack    = r_if_ack;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.mem_ack   = r_mem_ack;
  assign bus.stall_req = (bus.if_req & ~r_if_ack) | (bus.mem_req & ~r_mem_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level SRAM model
module tb_mem_arbiter;

  localparam int AC = 2;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   pass_cnt;

  mem_arbiter_if bus2 ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.ACCESS_CYCLES(AC)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  mem_arbiter #(.ACCESS_CYCLES(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input logic [15:0] a);
    case (a)
      16'h0004: return 16'h4E01;
      16'h8000: return 16'h1234;
      16'h0010: return 16'h6801;
      default:  return 16'((a * 3) ^ 16'hC3A5);
    endcase
  endfunction

  logic [15:0] sram [0:65535];
  bit          sram_ready;
  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 65536; i++) sram[i] = init_word(16'(i));
      sram_ready = 1'b1;
    end else if (bus2.ram_en && bus2.ram_we) begin
      sram[bus2.ram_addr] = bus2.ram_wdata;
    end
  end
  assign bus2.ram_rdata = sram[bus2.ram_addr];
  assign bus1.ram_rdata = bus1.ram_addr ^ 16'h5A5A;

  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_mem_rdata;
  logic [15:0] exp_if_data;

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic bit q_eq(input logic [15:0] a[$], input logic [15:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  int          o_if_cyc, o_mem_cyc, o_stall_low, o_we_cnt, o_extra;
  logic [15:0] o_if_d, o_mem_d;
  logic [15:0] o_addr_q[$];
  logic [15:0] o_wdata_q[$];

  // Drives one request set on bus2 from a negedge and records what the arbiter did.
  task automatic run_txn(input bit do_if, input logic [15:0] ia, input bit do_mem,
                         input bit we, input logic [15:0] ma, input logic [15:0] wd);
    bit if_p, mem_p;
    o_if_cyc = -1; o_mem_cyc = -1; o_stall_low = -1; o_we_cnt = 0; o_extra = 0;
    o_if_d = 'x; o_mem_d = 'x;
    o_addr_q.delete(); o_wdata_q.delete();
    bus2.if_req = do_if; bus2.if_addr = ia;
    bus2.mem_req = do_mem; bus2.mem_we = we; bus2.mem_addr = ma; bus2.mem_wdata = wd;
    if_p = do_if; mem_p = do_mem;
    for (int k = 1; k <= 30 && (if_p || mem_p); k++) begin
      @(negedge clk);
      if (bus2.ram_en) o_addr_q.push_back(bus2.ram_addr);
      if (bus2.ram_we) begin o_we_cnt++; o_wdata_q.push_back(bus2.ram_wdata); end
      if (o_stall_low < 0 && !bus2.stall_req) o_stall_low = k;
      if (bus2.if_ack) begin
        if (if_p) begin o_if_cyc = k; o_if_d = bus2.if_data; if_p = 0; bus2.if_req = 0; end
        else o_extra++;
      end
      if (bus2.mem_ack) begin
        if (mem_p) begin o_mem_cyc = k; o_mem_d = bus2.mem_rdata; mem_p = 0; bus2.mem_req = 0; end
        else o_extra++;
      end
    end
    bus2.if_req = 0; bus2.mem_req = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus2.if_ack || bus2.mem_ack || bus2.ram_en) o_extra++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] zero16;
    zero16 = '0;
    for (int i = 0; i < 4; i++) begin
      bus2.if_req = 1'($urandom); bus2.if_addr = 16'($urandom);
      bus2.mem_req = 1'($urandom); bus2.mem_we = 1'($urandom);
      bus2.mem_addr = 16'($urandom); bus2.mem_wdata = 16'($urandom);
      #1;
      chk_cnt++;
      if ({bus2.ram_en, bus2.ram_we, bus2.if_ack, bus2.mem_ack} !== 4'b0 ||
          bus2.ram_addr !== zero16 || bus2.ram_wdata !== zero16 ||
          bus2.if_data !== zero16 || bus2.mem_rdata !== zero16)
        $display("FAIL reset_outputs[%0d] en=%b we=%b ack=%b/%b addr=%h wd=%h ifd=%h mrd=%h required all 0",
                 i, bus2.ram_en, bus2.ram_we, bus2.if_ack, bus2.mem_ack,
                 bus2.ram_addr, bus2.ram_wdata, bus2.if_data, bus2.mem_rdata);
      else pass_cnt++;
      chk_cnt++;
      if (bus2.stall_req !== (bus2.if_req | bus2.mem_req))
        $display("FAIL reset_stall[%0d] got %b required %b", i, bus2.stall_req, bus2.if_req | bus2.mem_req);
      else pass_cnt++;
      #4;
    end
    bus2.if_req = 0; bus2.mem_req = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_cnt++;
      if (bus2.ram_en !== 1'b0 || bus2.stall_req !== 1'b0 || bus1.ram_en !== 1'b0)
        $display("FAIL reset_release_idle got en=%b stall=%b en1=%b required 0 0 0",
                 bus2.ram_en, bus2.stall_req, bus1.ram_en);
      else pass_cnt++;
    end
  endtask

  task automatic test_if_read();
    logic [15:0] exp_q[$];
    exp_q = '{16'h0004, 16'h0004};
    run_txn(1, 16'h0004, 0, 0, 16'h0, 16'h0);
    chk_cnt++;
    if (o_if_cyc != AC + 1) $display("FAIL if_read_latency got %0d required %0d", o_if_cyc, AC + 1);
    else pass_cnt++;
    chk_cnt++;
    if (o_if_d !== 16'h4E01) $display("FAIL if_read_data got %h required 4e01", o_if_d);
    else pass_cnt++;
    chk_cnt++;
    if (!q_eq(o_addr_q, exp_q) || o_we_cnt != 0)
      $display("FAIL if_read_ram got %p we_cycles=%0d required %p we_cycles=0", o_addr_q, o_we_cnt, exp_q);
    else pass_cnt++;
    chk_cnt++;
    if (o_stall_low != AC + 1 || o_extra != 0)
      $display("FAIL if_read_stall got low_at=%0d extra=%0d required %0d 0", o_stall_low, o_extra, AC + 1);
    else pass_cnt++;
    exp_if_data = 16'h4E01;
  endtask

  task automatic test_mem_write();
    logic [15:0] exp_a[$];
    logic [15:0] exp_w[$];
    exp_a = '{16'hBF00, 16'hBF00};
    exp_w = '{16'h00AA, 16'h00AA};
    run_txn(0, 16'h0, 1, 1, 16'hBF00, 16'h00AA);
    ref_mem[16'hBF00] = 16'h00AA;
    chk_cnt++;
    if (o_we_cnt != AC || !q_eq(o_addr_q, exp_a) || !q_eq(o_wdata_q, exp_w))
      $display("FAIL mem_write_ram got we=%0d addr=%p wdata=%p required we=%0d addr=%p wdata=%p",
               o_we_cnt, o_addr_q, o_wdata_q, AC, exp_a, exp_w);
    else pass_cnt++;
    chk_cnt++;
    if (o_mem_cyc != AC + 1 || o_extra != 0)
      $display("FAIL mem_write_ack got at=%0d extra=%0d required %0d 0", o_mem_cyc, o_extra, AC + 1);
    else pass_cnt++;
    chk_cnt++;
    if (o_mem_d !== exp_mem_rdata)
      $display("FAIL mem_write_rdata_held got %h required %h", o_mem_d, exp_mem_rdata);
    else pass_cnt++;
  endtask

  task automatic test_conflict();
    logic [15:0] exp_q[$];
    exp_q = '{16'h8000, 16'h8000, 16'h0010, 16'h0010};
    run_txn(1, 16'h0010, 1, 0, 16'h8000, 16'h0);
    chk_cnt++;
    if (o_mem_cyc != AC + 1 || o_mem_d !== 16'h1234)
      $display("FAIL conflict_mem got at=%0d data=%h required %0d 1234", o_mem_cyc, o_mem_d, AC + 1);
    else pass_cnt++;
    chk_cnt++;
    if (o_if_cyc != 2 * AC + 2 || o_if_d !== 16'h6801)
      $display("FAIL conflict_if got at=%0d data=%h required %0d 6801", o_if_cyc, o_if_d, 2 * AC + 2);
    else pass_cnt++;
    chk_cnt++;
    if (!q_eq(o_addr_q, exp_q)) $display("FAIL conflict_order got %p required %p", o_addr_q, exp_q);
    else pass_cnt++;
    chk_cnt++;
    if (o_stall_low != 2 * AC + 2) $display("FAIL conflict_stall got low_at=%0d required %0d", o_stall_low, 2 * AC + 2);
    else pass_cnt++;
    exp_mem_rdata = 16'h1234;
    exp_if_data = 16'h6801;
  endtask

  task automatic test_reset_mid_write();
    int acks;
    bus2.mem_req = 1; bus2.mem_we = 1; bus2.mem_addr = 16'h0123; bus2.mem_wdata = 16'hBEEF;
    @(negedge clk);
    chk_cnt++;
    if (bus2.ram_we !== 1'b1) $display("FAIL midrst_we_before got %b required 1", bus2.ram_we);
    else pass_cnt++;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (bus2.ram_we !== 1'b0 || bus2.ram_en !== 1'b0)
      $display("FAIL midrst_async got we=%b en=%b required 0 0", bus2.ram_we, bus2.ram_en);
    else pass_cnt++;
    bus2.mem_req = 0;
    exp_mem_rdata = '0;
    exp_if_data = '0;
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus2.mem_ack || bus2.ram_en) acks++;
    end
    chk_cnt++;
    if (acks != 0 || bus2.mem_rdata !== 16'h0)
      $display("FAIL midrst_no_ack got activity=%0d rdata=%h required 0 0000", acks, bus2.mem_rdata);
    else pass_cnt++;
    run_txn(0, 16'h0, 1, 1, 16'h0123, 16'hBEEF);
    ref_mem[16'h0123] = 16'hBEEF;
    chk_cnt++;
    if (o_mem_cyc != AC + 1 || o_we_cnt != AC)
      $display("FAIL midrst_reissue got at=%0d we=%0d required %0d %0d", o_mem_cyc, o_we_cnt, AC + 1, AC);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] en_q[$], ack_q[$], addr_q[$], d_q[$];
    logic [15:0] exp_en[$], exp_ack[$], exp_addr[$], exp_d[$];
    int idx;
    exp_en = '{16'd1, 16'd4, 16'd7};
    exp_ack = '{16'd2, 16'd5, 16'd8};
    exp_addr = '{16'h0000, 16'h0001, 16'h0002};
    exp_d = '{16'h5A5A, 16'h5A5B, 16'h5A58};
    idx = 0;
    bus1.if_req = 1; bus1.if_addr = 16'h0000;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus1.ram_en) begin en_q.push_back(16'(k)); addr_q.push_back(bus1.ram_addr); end
      if (bus1.if_ack) begin
        ack_q.push_back(16'(k)); d_q.push_back(bus1.if_data);
        idx++;
        if (idx == 3) bus1.if_req = 0;
        else bus1.if_addr = 16'(idx);
      end
    end
    bus1.if_req = 0;
    chk_cnt++;
    if (!q_eq(en_q, exp_en)) $display("FAIL b2b_grant_cycles got %p required %p", en_q, exp_en);
    else pass_cnt++;
    chk_cnt++;
    if (!q_eq(ack_q, exp_ack)) $display("FAIL b2b_ack_cycles got %p required %p", ack_q, exp_ack);
    else pass_cnt++;
    chk_cnt++;
    if (!q_eq(addr_q, exp_addr)) $display("FAIL b2b_addr_seq got %p required %p", addr_q, exp_addr);
    else pass_cnt++;
    chk_cnt++;
    if (!q_eq(d_q, exp_d)) $display("FAIL b2b_data got %p required %p", d_q, exp_d);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [15:0] exp_a[$], exp_w[$];
    int mode, e_if_cyc, e_last;
    bit do_if, do_mem, we;
    logic [15:0] ia, ma, wd;
    for (int t = 0; t < 40; t++) begin
      mode = int'($urandom_range(0, 2));
      do_if = (mode != 1); do_mem = (mode != 0);
      we = 1'($urandom);
      ia = 16'($urandom); ma = 16'($urandom); wd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ia = ma;
      exp_a.delete(); exp_w.delete();
      if (do_mem) begin
        for (int c = 0; c < AC; c++) begin
          exp_a.push_back(ma);
          if (we) exp_w.push_back(wd);
        end
        if (we) ref_mem[ma] = wd;
        else exp_mem_rdata = ref_read(ma);
      end
      if (do_if) begin
        for (int c = 0; c < AC; c++) exp_a.push_back(ia);
        exp_if_data = ref_read(ia);
      end
      e_if_cyc = do_mem ? 2 * AC + 2 : AC + 1;
      e_last = do_if ? e_if_cyc : AC + 1;
      run_txn(do_if, ia, do_mem, we, ma, wd);
      if (do_mem) begin
        chk_cnt++;
        if (o_mem_cyc != AC + 1 || o_mem_d !== exp_mem_rdata)
          $display("FAIL rand_mem[%0d] got at=%0d data=%h required %0d %h",
                   t, o_mem_cyc, o_mem_d, AC + 1, exp_mem_rdata);
        else pass_cnt++;
      end
      if (do_if) begin
        chk_cnt++;
        if (o_if_cyc != e_if_cyc || o_if_d !== exp_if_data)
          $display("FAIL rand_if[%0d] got at=%0d data=%h required %0d %h",
                   t, o_if_cyc, o_if_d, e_if_cyc, exp_if_data);
        else pass_cnt++;
      end
      chk_cnt++;
      if (!q_eq(o_addr_q, exp_a) || !q_eq(o_wdata_q, exp_w) || o_stall_low != e_last || o_extra != 0)
        $display("FAIL rand_bus[%0d] got addr=%p wdata=%p stall_low=%0d extra=%0d required addr=%p wdata=%p stall_low=%0d extra=0",
                 t, o_addr_q, o_wdata_q, o_stall_low, o_extra, exp_a, exp_w, e_last);
      else pass_cnt++;
    end
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0;
    rst = 1'b0;
    exp_mem_rdata = '0; exp_if_data = '0;
    bus1.if_req = 0; bus1.if_addr = '0; bus1.mem_req = 0; bus1.mem_we = 0;
    bus1.mem_addr = '0; bus1.mem_wdata = '0;
    bus2.if_req = 0; bus2.if_addr = '0; bus2.mem_req = 0; bus2.mem_we = 0;
    bus2.mem_addr = '0; bus2.mem_wdata = '0;
    test_reset();
    test_if_read();
    test_mem_write();
    test_conflict();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
